gayle_mc: RTL and testbench

- Multi-channel, fully synchronous successor to the single-bit Gayle IDE interrupt/ID block.
- Decodes the Gayle register windows ($DA8000 regs, $DE0000 ID) on the 68030 local bus.
- Provides byte-wide STATUS/INTCHG/INTENA registers for up to 4 IDE interrupt sources, with per-channel edge or level mode, plus the serial Gayle ID shifter.
- Drives the active-low INT2 request and a synchronous ACK to the bus-termination logic.

---
 rtl/gayle_mc.sv | 197 +++++++++++++++++++
 tb/tb_gayle_mc.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gayle_mc.sv
// gayle_mc: Gayle-compatible IDE interrupt controller and ID shifter.
// Decodes the $DA8000 register window and the $DE0000 ID window on the
// 68030 local bus. Holds STATUS/INTCHG/INTENA for up to four IDE interrupt
// sources and drives the active-low INT2 request and a registered bus ACK.
// Channel i appears on data bit 7-i in every register.

module gayle_mc #(
    parameter int          NUM_CH       = 2,
    parameter logic [3:0]  GAYLE_ID_VAL = 4'hD,
    parameter logic [16:0] REGS_BASE    = 17'h1B5,
    parameter logic [16:0] ID_BASE      = 17'h1BC,
    parameter logic [3:0]  LEVEL_MASK   = 4'b0000
) (
    input  logic              CLKCPU,
    input  logic              RESET,
    input  logic              AS20,
    input  logic              DS20,
    input  logic              RW,
    input  logic [31:0]       A,
    input  logic [7:0]        DIN,
    input  logic [NUM_CH-1:0] IDE_INT,
    output logic [7:0]        DOUT,
    output logic              ACCESS,
    output logic              ACK,
    output logic              INT2
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACT,
        S_HOLD
    } bus_state_e;

    typedef enum logic [1:0] {
        R_STATUS = 2'd0,
        R_INTCHG = 2'd1,
        R_INTENA = 2'd2,
        R_RSVD   = 2'd3
    } reg_sel_e;

    // 1 = channel follows the synchronised level, 0 = latches rising edges.
    localparam logic [NUM_CH-1:0] LVL = LEVEL_MASK[NUM_CH-1:0];

    // Place the channel vector onto the byte lane (channel i -> bit 7-i).
    function automatic logic [7:0] ch_to_byte(input logic [NUM_CH-1:0] v);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            b[7-i] = v[i];
        end
        return b;
    endfunction

    // Extract the channel vector from the byte lane.
    function automatic logic [NUM_CH-1:0] byte_to_ch(input logic [7:0] b);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i] = b[7-i];
        end
        return v;
    endfunction

    bus_state_e        state_q, state_d;
    logic              ds_prev_q, ds_prev_d;
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic [NUM_CH-1:0] hist_q, hist_d;
    logic [NUM_CH-1:0] intchg_q, intchg_d;
    logic [NUM_CH-1:0] intena_q, intena_d;
    logic [3:0]        id_q, id_d;
    logic [7:0]        dout_q, dout_d;
    logic              ack_q, ack_d;
    logic              int2_q, int2_d;

    logic              hit_regs;
    logic              hit_id;
    logic              sel_id;
    reg_sel_e          reg_sel;
    logic              do_rd;
    logic              do_wr;
    logic [NUM_CH-1:0] din_ch;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] keep;

    // Address bits below the window that select nothing, and unmapped lanes.
    logic              unused_bits;
    assign unused_bits = ^{A[14], A[11:0], DIN};

    assign hit_regs = (A[31:15] == REGS_BASE);
    assign hit_id   = (A[31:15] == ID_BASE);
    assign ACCESS   = ~(hit_regs | hit_id);
    assign sel_id   = A[18];
    assign reg_sel  = reg_sel_e'(A[13:12]);
    assign do_rd    = (state_q == S_ACT) && RW;
    assign do_wr    = (state_q == S_ACT) && !RW;
    assign din_ch   = byte_to_ch(DIN);
    assign rise     = sync2_q & ~hist_q;

    // Bus-cycle sequencing: one action per strobe edge, ACK while holding.
    always_comb begin
        // NOTE: defaults assigned first so no path leaves a signal unassigned (no latch).
        state_d   = state_q;
        ds_prev_d = DS20;
        unique case (state_q)
            S_IDLE: begin
                if (!AS20 && !DS20 && !ACCESS && ds_prev_q) begin
                    state_d = S_ACT;
                end
            end
            S_ACT:  state_d = S_HOLD;
            S_HOLD: begin
                if (AS20 || DS20) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ack_d = (state_d == S_HOLD);
    end

    // Register file, interrupt bookkeeping and the ID shifter.
    always_comb begin
        sync1_d  = IDE_INT;
        sync2_d  = sync1_q;
        hist_d   = sync2_q;
        intena_d = intena_q;
        id_d     = id_q;
        dout_d   = dout_q;
        keep     = '1;

        if (do_wr) begin
            if (sel_id) begin
                id_d = GAYLE_ID_VAL;
            end else begin
                case (reg_sel)
                    R_INTCHG: keep     = din_ch;
                    R_INTENA: intena_d = din_ch;
                    default:  ;
                endcase
            end
        end

        if (do_rd) begin
            if (sel_id) begin
                dout_d = {id_q[3], 7'b0};
                id_d   = {id_q[2:0], 1'b1};
            end else begin
                case (reg_sel)
                    R_STATUS: dout_d = ch_to_byte(sync2_q);
                    R_INTCHG: dout_d = ch_to_byte(intchg_q);
                    R_INTENA: dout_d = ch_to_byte(intena_q);
                    default:  dout_d = '0;
                endcase
            end
        end

        // Edge channels: clear-by-write, but a new edge in the same cycle wins.
        intchg_d = (LVL & sync2_q) | (~LVL & ((intchg_q & keep) | rise));
        int2_d   = ~|(intchg_q & intena_q);
    end

    // All state, with synchronous reset; synchronisers reset high so no edge on exit.
    always_ff @(posedge CLKCPU) begin
        // NOTE: non-blocking so every flop samples the values from before this edge.
        if (RESET) begin
            state_q   <= S_IDLE;
            ds_prev_q <= 1'b0;
            sync1_q   <= '1;
            sync2_q   <= '1;
            hist_q    <= '1;
            intchg_q  <= '0;
            intena_q  <= '0;
            id_q      <= GAYLE_ID_VAL;
            dout_q    <= '0;
            ack_q     <= 1'b0;
            int2_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            ds_prev_q <= ds_prev_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            intchg_q  <= intchg_d;
            intena_q  <= intena_d;
            id_q      <= id_d;
            dout_q    <= dout_d;
            ack_q     <= ack_d;
            int2_q    <= int2_d;
        end
    end

    assign DOUT = dout_q;
    assign ACK  = ack_q;
    assign INT2 = int2_q;

endmodule

// File: tb/tb_gayle_mc.sv
// Self-checking bench for gayle_mc: a register-access table, hand-written
// timing sequences, and a randomized run against a transaction-level model.

module tb_gayle_mc;

    localparam int          NUM_CH   = 2;
    localparam logic [3:0]  ID_VAL   = 4'hD;
    localparam logic [31:0] A_STATUS = 32'h00DA_8000;
    localparam logic [31:0] A_INTCHG = 32'h00DA_9000;
    localparam logic [31:0] A_INTENA = 32'h00DA_A000;
    localparam logic [31:0] A_RSVD   = 32'h00DA_B000;
    localparam logic [31:0] A_ID     = 32'h00DE_1000;
    localparam logic [31:0] A_NONE   = 32'h00DB_2000;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        rd;
        logic [7:0]  wdata;
        logic [7:0]  expv;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              as_n = 1'b1;
    logic              ds_n = 1'b1;
    logic              rw = 1'b1;
    logic [31:0]       addr = '0;
    logic [7:0]        din = '0;
    logic [NUM_CH-1:0] ide = '0;
    logic [7:0]        dout, dout_l;
    logic              access, access_l;
    logic              ack, ack_l;
    logic              int2, int2_l;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gayle_mc #(.NUM_CH(NUM_CH)) dut (
        .CLKCPU(clk), .RESET(rst), .AS20(as_n), .DS20(ds_n), .RW(rw),
        .A(addr), .DIN(din), .IDE_INT(ide),
        .DOUT(dout), .ACCESS(access), .ACK(ack), .INT2(int2)
    );

    gayle_mc #(.NUM_CH(NUM_CH), .LEVEL_MASK(4'b0001)) dut_lvl (
        .CLKCPU(clk), .RESET(rst), .AS20(as_n), .DS20(ds_n), .RW(rw),
        .A(addr), .DIN(din), .IDE_INT(ide),
        .DOUT(dout_l), .ACCESS(access_l), .ACK(ack_l), .INT2(int2_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] to_byte(input logic [NUM_CH-1:0] v);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < NUM_CH; i++) b[7-i] = v[i];
        return b;
    endfunction

    function automatic logic [NUM_CH-1:0] to_ch(input logic [7:0] b);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = b[7-i];
        return v;
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] a, input logic r,
                                input logic [7:0] w, input logic [7:0] e);
        vec_t v;
        v.name = n; v.addr = a; v.rd = r; v.wdata = w; v.expv = e;
        return v;
    endfunction

    // One decoded bus cycle; ACK must arrive two clocks after the strobes fall.
    task automatic bus_xfer(input logic [31:0] a, input logic rd, input logic [7:0] w,
                            input int hold, output logic [7:0] rdata, output logic [7:0] rdata_l);
        int waited;
        @(negedge clk);
        addr = a; rw = rd; din = w; as_n = 1'b0; ds_n = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ack && waited < 8);
        check("ack_latency", waited, 2);
        rdata = dout;
        rdata_l = dout_l;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ack_held", 32'(ack), 1);
            check("dout_stable", 32'(dout), 32'(rdata));
        end
        as_n = 1'b1; ds_n = 1'b1;
        @(negedge clk);
        check("ack_release", 32'(ack), 0);
    endtask

    // An access outside both windows: no ACK, ACCESS high, DOUT untouched.
    task automatic nodec(input logic [31:0] a, input logic rd, input logic [7:0] w,
                         input logic chk_dout, input logic [7:0] exp_dout);
        @(negedge clk);
        addr = a; rw = rd; din = w; as_n = 1'b0; ds_n = 1'b0;
        @(negedge clk);
        check("nodec_access", 32'(access), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nodec_ack", 32'(ack), 0);
        end
        if (chk_dout) check("nodec_dout", 32'(dout), 32'(exp_dout));
        as_n = 1'b1; ds_n = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; as_n = 1'b1; ds_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin : watchdog
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl[$];
        logic [7:0] r, rl;
        logic [NUM_CH-1:0] m_ide, m_intchg, m_intena, nv;
        logic [3:0] m_id;
        logic [7:0] m_dout, e;
        logic m_dout_ok;
        logic [14:0] lo;
        logic [31:0] a, na;
        int op, sel;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_int2", 32'(int2), 1);
        check("rst_int2_lvl", 32'(int2_l), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Register table
        tbl.push_back(mk("id_r1", A_ID, 1, 8'h00, 8'h80));
        tbl.push_back(mk("id_r2", A_ID, 1, 8'h00, 8'h80));
        tbl.push_back(mk("id_r3", A_ID, 1, 8'h00, 8'h00));
        tbl.push_back(mk("id_r4", A_ID, 1, 8'h00, 8'h80));
        tbl.push_back(mk("id_r5", A_ID, 1, 8'h00, 8'h80));
        tbl.push_back(mk("id_w", A_ID, 0, 8'h00, 8'h00));
        tbl.push_back(mk("id_rl1", A_ID, 1, 8'h00, 8'h80));
        tbl.push_back(mk("id_rl2", A_ID, 1, 8'h00, 8'h80));
        tbl.push_back(mk("id_rl3", A_ID, 1, 8'h00, 8'h00));
        tbl.push_back(mk("id_w2", A_ID, 0, 8'hFF, 8'h00));
        tbl.push_back(mk("id_rl4", A_ID, 1, 8'h00, 8'h80));
        tbl.push_back(mk("ena_w", A_INTENA, 0, 8'hC0, 8'h00));
        tbl.push_back(mk("ena_r", A_INTENA, 1, 8'h00, 8'hC0));
        tbl.push_back(mk("ena_wff", A_INTENA, 0, 8'hFF, 8'h00));
        tbl.push_back(mk("ena_rff", A_INTENA, 1, 8'h00, 8'hC0));
        tbl.push_back(mk("ena_w3f", A_INTENA, 0, 8'h3F, 8'h00));
        tbl.push_back(mk("ena_r3f", A_INTENA, 1, 8'h00, 8'h00));
        tbl.push_back(mk("ena_w40", A_INTENA, 0, 8'h40, 8'h00));
        tbl.push_back(mk("ena_r40", A_INTENA, 1, 8'h00, 8'h40));
        tbl.push_back(mk("rsvd_r", A_RSVD, 1, 8'h00, 8'h00));
        tbl.push_back(mk("rsvd_w", A_RSVD, 0, 8'hFF, 8'h00));
        tbl.push_back(mk("rsvd_r2", A_RSVD, 1, 8'h00, 8'h00));
        tbl.push_back(mk("stat_r", A_STATUS, 1, 8'h00, 8'h00));
        tbl.push_back(mk("stat_w", A_STATUS, 0, 8'hFF, 8'h00));
        tbl.push_back(mk("stat_r2", A_STATUS, 1, 8'h00, 8'h00));
        tbl.push_back(mk("chg_r", A_INTCHG, 1, 8'h00, 8'h00));
        tbl.push_back(mk("ena_keep", A_INTENA, 1, 8'h00, 8'h40));
        foreach (tbl[i]) begin
            bus_xfer(tbl[i].addr, tbl[i].rd, tbl[i].wdata, 0, r, rl);
            if (tbl[i].rd) check(tbl[i].name, 32'(r), 32'(tbl[i].expv));
        end

        // Edge latency: INT2 falls exactly 4 clocks after IDE_INT rises
        do_reset();
        bus_xfer(A_INTENA, 0, 8'hC0, 0, r, rl);
        @(negedge clk); ide = 2'b01;
        @(negedge clk);
        @(negedge clk); ide = 2'b00;
        @(negedge clk);
        check("int2_pre_edge", 32'(int2), 1);
        @(negedge clk);
        check("int2_edge_lat", 32'(int2), 0);
        bus_xfer(A_INTCHG, 1, 8'h00, 0, r, rl);
        check("chg_edge", 32'(r), 'h80);
        bus_xfer(A_INTCHG, 0, 8'h7F, 0, r, rl);
        bus_xfer(A_INTCHG, 1, 8'h00, 0, r, rl);
        check("chg_cleared", 32'(r), 'h00);
        check("int2_cleared", 32'(int2), 1);

        // Set wins over a coincident clear
        @(negedge clk); ide = 2'b01;
        bus_xfer(A_INTCHG, 0, 8'h00, 0, r, rl);
        bus_xfer(A_INTCHG, 1, 8'h00, 0, r, rl);
        check("set_wins", 32'(r), 'h80);
        check("set_wins_int2", 32'(int2), 0);
        ide = 2'b00;
        bus_xfer(A_INTCHG, 0, 8'h00, 0, r, rl);
        bus_xfer(A_INTCHG, 1, 8'h00, 0, r, rl);
        check("clr_after", 32'(r), 'h00);

        // Line already high across reset release: no edge
        ide = 2'b10;
        do_reset();
        bus_xfer(A_INTCHG, 1, 8'h00, 0, r, rl);
        check("no_spurious", 32'(r), 'h00);
        bus_xfer(A_STATUS, 1, 8'h00, 0, r, rl);
        check("status_ch1", 32'(r), 'h40);
        bus_xfer(A_INTENA, 0, 8'hC0, 0, r, rl);
        repeat (3) @(negedge clk);
        check("no_spur_int2", 32'(int2), 1);
        ide = 2'b00;

        // Level-mode channel 0 on dut_lvl
        do_reset();
        bus_xfer(A_INTENA, 0, 8'h80, 0, r, rl);
        @(negedge clk); ide = 2'b01;
        repeat (3) @(negedge clk);
        check("lvl_int2_pre", 32'(int2_l), 1);
        @(negedge clk);
        check("lvl_int2_low", 32'(int2_l), 0);
        bus_xfer(A_INTCHG, 1, 8'h00, 0, r, rl);
        check("lvl_chg", 32'(rl), 'h80);
        check("edge_chg", 32'(r), 'h80);
        bus_xfer(A_INTCHG, 0, 8'h00, 0, r, rl);
        bus_xfer(A_INTCHG, 1, 8'h00, 0, r, rl);
        check("lvl_wr_ignored", 32'(rl), 'h80);
        check("edge_wr_clears", 32'(r), 'h00);
        check("lvl_int2_still", 32'(int2_l), 0);
        check("edge_int2_high", 32'(int2), 1);
        @(negedge clk); ide = 2'b00;
        repeat (4) @(negedge clk);
        check("lvl_int2_release", 32'(int2_l), 1);
        bus_xfer(A_INTCHG, 1, 8'h00, 0, r, rl);
        check("lvl_chg_low", 32'(rl), 'h00);
        check("lvl_ack_seen", 32'(ack_l), 0);

        // Long strobes, non-decoded access, reset in HOLD
        do_reset();
        bus_xfer(A_INTENA, 0, 8'h80, 0, r, rl);
        bus_xfer(A_INTENA, 1, 8'h00, 10, r, rl);
        check("long_ena", 32'(r), 'h80);
        bus_xfer(A_ID, 1, 8'h00, 10, r, rl);
        check("long_id1", 32'(r), 'h80);
        bus_xfer(A_ID, 1, 8'h00, 0, r, rl);
        check("long_id2", 32'(r), 'h80);
        bus_xfer(A_ID, 1, 8'h00, 0, r, rl);
        check("long_id3", 32'(r), 'h00);
        nodec(A_NONE, 0, 8'hFF, 1, 8'h00);
        check("nodec_access_lvl", 32'(access_l), 1);
        bus_xfer(A_INTENA, 1, 8'h00, 0, r, rl);
        check("nodec_ena_kept", 32'(r), 'h80);
        bus_xfer(A_ID, 1, 8'h00, 0, r, rl);
        check("nodec_id_kept", 32'(r), 'h80);
        @(negedge clk);
        addr = A_INTENA; rw = 1'b1; as_n = 1'b0; ds_n = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_ack", 32'(ack), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_hold_ack", 32'(ack), 0);
        check("rst_hold_dout", 32'(dout), 0);
        rst = 1'b0; as_n = 1'b1; ds_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_ack", 32'(ack), 0);
        bus_xfer(A_INTENA, 1, 8'h00, 0, r, rl);
        check("post_rst_ena", 32'(r), 'h00);

        // Randomized run against a transaction-level model
        ide = '0;
        do_reset();
        m_ide = '0; m_intchg = '0; m_intena = '0; m_id = ID_VAL;
        m_dout = '0; m_dout_ok = 1'b1;
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            sel = $urandom_range(0, 4);
            lo = 15'($urandom);
            lo[13:12] = 2'(sel);
            a = (sel == 4) ? {17'h1BC, lo} : {17'h1B5, lo};
            if (op <= 1) begin
                nv = NUM_CH'($urandom);
                @(negedge clk); ide = nv;
                m_intchg = m_intchg | (nv & ~m_ide);
                m_ide = nv;
                repeat (5) @(negedge clk);
            end else if (op <= 5) begin
                case (sel)
                    0: e = to_byte(m_ide);
                    1: e = to_byte(m_intchg);
                    2: e = to_byte(m_intena);
                    3: e = 8'h00;
                    default: begin
                        e = {m_id[3], 7'b0};
                        m_id = {m_id[2:0], 1'b1};
                    end
                endcase
                bus_xfer(a, 1, 8'h00, $urandom_range(0, 3), r, rl);
                check("rnd_read", 32'(r), 32'(e));
                m_dout = e; m_dout_ok = 1'b1;
            end else if (op <= 8) begin
                e = 8'($urandom);
                case (sel)
                    1: m_intchg = m_intchg & to_ch(e);
                    2: m_intena = to_ch(e);
                    4: m_id = ID_VAL;
                    default: ;
                endcase
                bus_xfer(a, 0, e, $urandom_range(0, 3), r, rl);
                m_dout_ok = 1'b0;
            end else begin
                na = $urandom;
                while (na[31:15] == 17'h1B5 || na[31:15] == 17'h1BC) na = $urandom;
                nodec(na, 1'($urandom), 8'($urandom), m_dout_ok, m_dout);
            end
            @(negedge clk);
            check("rnd_int2", 32'(int2), 32'(~|(m_intchg & m_intena)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
